// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, marker default, fetch state and queue entry types
package fetch_unit_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 64;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] END_MARKER_DEF = 32'hABCDDCBA;
    typedef enum logic {FETCH, HALT} fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode handshake bundle
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic dec_ready;
    logic dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic halted;
    modport master(
        output imem_addr, dec_valid, dec_instr, dec_pc, halted,
        input imem_data, redirect, redirect_pc, dec_ready
    );
    modport slave(
        input imem_addr, dec_valid, dec_instr, dec_pc, halted,
        output imem_data, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched entries with flush and push-while-full-and-popping
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);
    localparam int PW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [PW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rptr];
    // storage is cleared on reset so the head reads zero; flush only rewinds the pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, memory settle counter and halt FSM feeding a fetch queue toward decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [INSTR_W-1:0] END_MARKER = END_MARKER_DEF
) (
    input logic clk,
    input logic rst,
    fetch_unit_if.master bus
);
    localparam logic [2:0] WAIT = 3'(MEM_WAIT_CYCLES);
    fetch_state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [2:0] wcnt, wcnt_n;
    logic settled, marker, push, pop, full, empty;
    entry_t wr_entry, head;
    assign settled = state == FETCH && wcnt == WAIT;
    assign marker = settled && bus.imem_data == END_MARKER;
    assign pop = !empty && bus.dec_ready;
    assign push = settled && !marker && (!full || pop);
    assign wr_entry = '{pc: pc, instr: bus.imem_data};
    assign bus.imem_addr = pc;
    assign bus.dec_valid = !empty;
    assign bus.dec_instr = head.instr;
    assign bus.dec_pc = head.pc;
    assign bus.halted = state == HALT;
    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk(clk),
        .rst(rst),
        .flush(bus.redirect),
        .push(push),
        .pop(pop),
        .din(wr_entry),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    // state, PC and settle counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            wcnt <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            wcnt <= wcnt_n;
        end
    end
    // redirect wins; otherwise settle, halt on marker, or advance after a push
    always_comb begin
        state_n = state;
        pc_n = pc;
        wcnt_n = wcnt;
        if (bus.redirect) begin
            state_n = FETCH;
            pc_n = bus.redirect_pc & ~ADDR_W'(3);
            wcnt_n = '0;
        end else if (state == FETCH) begin
            if (wcnt < WAIT) wcnt_n = wcnt + 3'd1;
            else if (marker) state_n = HALT;
            else if (push) begin
                pc_n = pc + ADDR_W'(PC_STEP);
                wcnt_n = '0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random redirect/backpressure/reset against a queue-based reference
module tb_fetch_unit;
    import fetch_unit_pkg::*;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam int MWC = 1;
    localparam int DEPTH = 2;
    localparam logic [31:0] MARK = 32'hABCDDCBA;
    logic clk = 0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [63:0] m_pc;
    int m_settle;
    bit m_halt;
    entry_t m_q[$];
    fetch_unit_if bus();
    fetch_unit_if bus1();
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [29:0] h;
        h = a[31:2] * 30'h1E3779B1 + 30'h0ACE1;
        if (a == 64'h58) return MARK;
        if (a == 64'h0) return 32'hF84003E9;
        if (a == 64'h4) return 32'hF84083EA;
        if (a == 64'h8) return 32'hF84103EB;
        return {h, 2'b11};
    endfunction
    assign bus.imem_data = mem_word(bus.imem_addr);
    assign bus1.imem_data = mem_word(bus1.imem_addr);
    fetch_unit #(.RESET_PC(RST_PC), .MEM_WAIT_CYCLES(MWC), .QUEUE_DEPTH(DEPTH), .END_MARKER(MARK)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    fetch_unit #(.RESET_PC(64'hFFFFFFFFFFFFFFFC), .MEM_WAIT_CYCLES(0), .QUEUE_DEPTH(4), .END_MARKER(MARK)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_step(input bit r, input bit rd, input logic [63:0] rpc, input bit dr);
        logic [31:0] w;
        if (r) begin
            m_pc = RST_PC;
            m_settle = 0;
            m_halt = 0;
            m_q.delete();
        end else if (rd) begin
            m_q.delete();
            m_pc = {rpc[63:2], 2'b00};
            m_settle = 0;
            m_halt = 0;
        end else begin
            if (dr && m_q.size() > 0) void'(m_q.pop_front());
            if (!m_halt) begin
                w = mem_word(m_pc);
                if (m_settle < MWC) m_settle++;
                else if (w == MARK) m_halt = 1;
                else if (m_q.size() < DEPTH) begin
                    m_q.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 64'd4;
                    m_settle = 0;
                end
            end
        end
    endtask
    task automatic cycle(input bit r, input bit rd, input logic [63:0] rpc, input bit dr);
        rst = r;
        bus.redirect = rd;
        bus.redirect_pc = rpc;
        bus.dec_ready = dr;
        @(posedge clk);
        model_step(r, rd, rpc, dr);
        #1;
        check("valid", bus.dec_valid, 64'(m_q.size() > 0));
        check("halted", bus.halted, 64'(m_halt));
        check("addr", bus.imem_addr, m_pc);
        if (m_q.size() > 0) begin
            check("dec_pc", bus.dec_pc, m_q[0].pc);
            check("dec_instr", bus.dec_instr, 64'(m_q[0].instr));
        end
    endtask
    initial begin
        bus1.redirect = 0;
        bus1.redirect_pc = '0;
        bus1.dec_ready = 1;
        cycle(1, 0, 0, 1);
        check("rst_instr", bus.dec_instr, 0);
        check("rst_pc", bus.dec_pc, 0);
        check("rst_valid", bus.dec_valid, 0);
        check("u1_rst_addr", bus1.imem_addr, 64'hFFFFFFFFFFFFFFFC);
        cycle(0, 0, 0, 1);
        check("lat_edge1", bus.dec_valid, 0);
        check("u1_valid", bus1.dec_valid, 1);
        check("u1_pc", bus1.dec_pc, 64'hFFFFFFFFFFFFFFFC);
        check("u1_wrap", bus1.imem_addr, 64'h0);
        cycle(0, 0, 0, 1);
        check("lat_edge2", bus.dec_valid, 1);
        check("first_pc", bus.dec_pc, 64'h0);
        check("first_instr", bus.dec_instr, 64'hF84003E9);
        repeat (2) cycle(0, 0, 0, 1);
        check("second_instr", bus.dec_instr, 64'hF84083EA);
        repeat (2) cycle(0, 0, 0, 1);
        check("third_instr", bus.dec_instr, 64'hF84103EB);
        cycle(1, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0);
        check("bp_addr", bus.imem_addr, 64'h8);
        check("bp_head", bus.dec_pc, 64'h0);
        cycle(0, 0, 0, 1);
        check("bp_pop0", bus.dec_pc, 64'h4);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h24, 0);
        repeat (4) cycle(0, 0, 0, 0);
        check("rd_pre_addr", bus.imem_addr, 64'h2C);
        check("rd_pre_head", bus.dec_pc, 64'h24);
        cycle(0, 1, 64'h1F, 1);
        check("rd_addr", bus.imem_addr, 64'h1C);
        check("rd_flush", bus.dec_valid, 0);
        repeat (2) cycle(0, 0, 0, 1);
        check("rd_entry_pc", bus.dec_pc, 64'h1C);
        check("rd_entry_instr", bus.dec_instr, 64'(mem_word(64'h1C)));
        cycle(0, 1, 64'h50, 0);
        repeat (6) cycle(0, 0, 0, 0);
        check("halt_set", bus.halted, 1);
        check("halt_head", bus.dec_pc, 64'h50);
        cycle(0, 0, 0, 1);
        check("halt_drain", bus.dec_pc, 64'h54);
        repeat (4) cycle(0, 0, 0, 1);
        check("halt_empty", bus.dec_valid, 0);
        check("halt_hold", bus.halted, 1);
        cycle(0, 1, 64'h34, 1);
        check("halt_clear", bus.halted, 0);
        check("halt_resume", bus.imem_addr, 64'h34);
        repeat (4) cycle(0, 0, 0, 1);
        for (int i = 0; i < 1500; i++)
            cycle($urandom % 97 == 0, $urandom % 13 == 0, 64'($urandom_range(0, 200)), $urandom % 3 != 0);
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("mid_rst_valid", bus.dec_valid, 0);
        check("mid_rst_halt", bus.halted, 0);
        check("mid_rst_addr", bus.imem_addr, RST_PC);
        repeat (6) cycle(0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
